// File: rtl/rv32i_instr_encoder_pkg.sv
// Shared constants for the RV32I instruction encoder: opcodes, command kinds,
// packing formats, FSM states and a small immediate range helper.
package rv32i_instr_encoder_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    KIND_R      = 4'd0,
    KIND_I_ALU  = 4'd1,
    KIND_LOAD   = 4'd2,
    KIND_STORE  = 4'd3,
    KIND_BRANCH = 4'd4,
    KIND_JAL    = 4'd5,
    KIND_JALR   = 4'd6,
    KIND_LUI    = 4'd7,
    KIND_AUIPC  = 4'd8,
    KIND_CSR    = 4'd9,
    KIND_LI     = 4'd10
  } cmd_kind_e;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EMIT  = 2'd1,
    ST_EMIT2 = 2'd2
  } state_e;

  // True when v is representable as a two's complement number of 'bits' bits:
  // everything from bit (bits-1) upwards is a copy of the sign.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] mask;
    mask = 32'hFFFF_FFFF << (bits - 1);
    return ((v & mask) == 32'h0) || ((v & mask) == mask);
  endfunction

endpackage

// File: rtl/rv32i_instr_encoder_field_pack.sv
// Combinational field packer: places opcode, register and function fields and
// scatters the immediate according to the selected RV32I instruction format.
module rv32i_field_pack
  import rv32i_instr_encoder_pkg::*;
(
  input  fmt_e        fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word
);

  // Format-specific bit placement; immediates are taken as already validated.
  always_comb begin
    word = 32'h0;
    case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: word = {imm[31:12], rd, opcode};
      FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: word = 32'h0;
    endcase
  end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// RV32I instruction encoder: accepts one structured command, validates it,
// and emits one instruction word (two for an expanded LI) downstream.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The producer holds valid and its payload stable until that
// edge; ready may change freely and carries no commitment on its own.
module rv32i_instr_encoder
  import rv32i_instr_encoder_pkg::*;
#(
  parameter int LI_EXPAND = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_kind,
  input  logic [2:0]  cmd_funct3,
  input  logic        cmd_alt,
  input  logic [4:0]  cmd_rd,
  input  logic [4:0]  cmd_rs1,
  input  logic [4:0]  cmd_rs2,
  input  logic [31:0] cmd_imm,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins_word,
  output logic        err
);

  state_e      state_q, state_n;
  logic [31:0] word_q, word_n;
  logic [31:0] word2_q, word2_n;
  logic        has2_q, has2_n;
  logic        err_q, err_n;

  logic        legal;
  logic        has2;
  fmt_e        fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic [31:0] enc_word;
  logic [31:0] enc_word2;
  logic        is_shift;
  logic        fits12;

  assign is_shift = (cmd_funct3 == 3'b001) || (cmd_funct3 == 3'b101);
  assign fits12   = fits_signed(cmd_imm, 12);

  // Command legality and selection of the fields for the first emitted word.
  always_comb begin
    legal  = 1'b0;
    has2   = 1'b0;
    fmt    = FMT_I;
    opcode = OP_IMM;
    funct3 = cmd_funct3;
    funct7 = 7'b0;
    rd     = cmd_rd;
    rs1    = cmd_rs1;
    rs2    = cmd_rs2;
    imm    = cmd_imm;
    case (cmd_kind_e'(cmd_kind))
      KIND_R: begin
        fmt    = FMT_R;
        opcode = OP_R;
        funct7 = {1'b0, cmd_alt, 5'b0};
        legal  = !cmd_alt || (cmd_funct3 == 3'b000) || (cmd_funct3 == 3'b101);
      end
      KIND_I_ALU: begin
        if (is_shift) begin
          // Shift amount occupies imm[4:0]; bit 30 selects SRAI.
          imm   = {20'b0, 1'b0, cmd_alt, 5'b0, cmd_imm[4:0]};
          legal = (cmd_imm[31:5] == 27'b0) && (!cmd_alt || cmd_funct3 == 3'b101);
        end else begin
          legal = !cmd_alt && fits12;
        end
      end
      KIND_LOAD: begin
        opcode = OP_LOAD;
        legal  = (cmd_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) && fits12;
      end
      KIND_STORE: begin
        fmt    = FMT_S;
        opcode = OP_STORE;
        legal  = (cmd_funct3 inside {3'b000, 3'b001, 3'b010}) && fits12;
      end
      KIND_BRANCH: begin
        fmt    = FMT_B;
        opcode = OP_BRANCH;
        legal  = (cmd_funct3 inside {3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111})
                 && !cmd_imm[0] && fits_signed(cmd_imm, 13);
      end
      KIND_JAL: begin
        fmt    = FMT_J;
        opcode = OP_JAL;
        legal  = !cmd_imm[0] && fits_signed(cmd_imm, 21);
      end
      KIND_JALR: begin
        opcode = OP_JALR;
        legal  = (cmd_funct3 == 3'b000) && fits12;
      end
      KIND_LUI: begin
        fmt    = FMT_U;
        opcode = OP_LUI;
        legal  = (cmd_imm[11:0] == 12'b0);
      end
      KIND_AUIPC: begin
        fmt    = FMT_U;
        opcode = OP_AUIPC;
        legal  = (cmd_imm[11:0] == 12'b0);
      end
      KIND_CSR: begin
        opcode = OP_SYSTEM;
        imm    = {20'b0, cmd_imm[11:0]};
        legal  = cmd_funct3 inside {3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
      end
      KIND_LI: begin
        legal  = (LI_EXPAND != 0);
        funct3 = 3'b000;
        if (fits12) begin
          rs1 = 5'd0;
        end else begin
          // Rounding the upper part compensates for the sign of the low ADDI.
          fmt    = FMT_U;
          opcode = OP_LUI;
          imm    = cmd_imm + 32'h0000_0800;
          has2   = (cmd_imm[11:0] != 12'b0);
        end
      end
      default: legal = 1'b0;
    endcase
  end

  rv32i_field_pack u_pack (
    .fmt    (fmt),
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .imm    (imm),
    .word   (enc_word)
  );

  // Low half of an expanded LI: ADDI rd, rd, imm[11:0].
  rv32i_field_pack u_pack_lo (
    .fmt    (FMT_I),
    .opcode (OP_IMM),
    .funct3 (3'b000),
    .funct7 (7'b0),
    .rd     (cmd_rd),
    .rs1    (cmd_rd),
    .rs2    (5'd0),
    .imm    ({20'b0, cmd_imm[11:0]}),
    .word   (enc_word2)
  );

  // Next-state and datapath updates for the IDLE/EMIT/EMIT2 sequence.
  always_comb begin
    state_n = state_q;
    word_n  = word_q;
    word2_n = word2_q;
    has2_n  = has2_q;
    err_n   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (legal) begin
            state_n = ST_EMIT;
            word_n  = enc_word;
            word2_n = enc_word2;
            has2_n  = has2;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      ST_EMIT: begin
        if (ins_ready) begin
          if (has2_q) begin
            state_n = ST_EMIT2;
            word_n  = word2_q;
            has2_n  = 1'b0;
          end else begin
            state_n = ST_IDLE;
            word_n  = 32'h0;
          end
        end
      end
      ST_EMIT2: begin
        if (ins_ready) begin
          state_n = ST_IDLE;
          word_n  = 32'h0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        word_n  = 32'h0;
        has2_n  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any pending word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      word_q  <= 32'h0;
      word2_q <= 32'h0;
      has2_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      word_q  <= word_n;
      word2_q <= word2_n;
      has2_q  <= has2_n;
      err_q   <= err_n;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign ins_valid = (state_q == ST_EMIT) || (state_q == ST_EMIT2);
  assign ins_word  = word_q;
  assign err       = err_q;

endmodule
